uart_avm_arbiter: RTL and testbench

UART_AVM_ARBITER -- requirements
Module: uart_avm_arbiter

---
 rtl/uart_avm_pkg.sv | 17 +
 rtl/uart_rr_pick.sv | 29 ++
 rtl/uart_avm_arbiter.sv | 108 ++++++++++
 tb/tb_uart_avm_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_avm_pkg.sv
// rtl/uart_avm_pkg.sv - shared constants and FSM state type for the UART Avalon-MM arbiter
package uart_avm_pkg;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;

  localparam int TX_OK_BIT = 6;
  localparam int RX_OK_BIT = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker starting one past last_grant
module uart_rr_pick #(
  parameter int NUM_REQ = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [IW-1:0]      grant,
  output logic               grant_vld
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest pending requester wins.
  always_comb begin
    grant     = last_grant;
    grant_vld = 1'b0;
    idx       = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = int'(last_grant) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        grant     = IW'(idx);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_avm_arbiter.sv
// rtl/uart_avm_arbiter.sv - round-robin arbiter of NUM_REQ Avalon masters onto one UART slave
// Optional wait timeout enabled by macro UART_ARB_TIMEOUT_EN.
module uart_avm_arbiter
  import uart_avm_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1024,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                  avm_clk,
  input  logic                  avm_rst,
  input  logic [NUM_REQ*5-1:0]  s_address,
  input  logic [NUM_REQ-1:0]    s_read,
  input  logic [NUM_REQ-1:0]    s_write,
  input  logic [NUM_REQ*32-1:0] s_writedata,
  output logic [31:0]           s_readdata,
  output logic [NUM_REQ-1:0]    s_waitrequest,
  output logic [NUM_REQ-1:0]    s_timeout,
  output logic [4:0]            avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [31:0]           avm_writedata,
  input  logic [31:0]           avm_readdata,
  input  logic                  avm_waitrequest
);

  arb_state_t     state, state_nxt;
  logic [IW-1:0]  grant, last_grant, pick;
  logic           pick_vld;
  logic           done;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (s_read | s_write),
    .last_grant (last_grant),
    .grant      (pick),
    .grant_vld  (pick_vld)
  );

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        timeout_hit;

  assign timeout_hit = (state == S_BUSY) && avm_waitrequest && (wait_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst)                              wait_cnt <= '0;
    else if (state == S_BUSY && avm_waitrequest) wait_cnt <= wait_cnt + 16'd1;
    else                                      wait_cnt <= '0;
  end
`endif

  always_comb begin
    state_nxt     = state;
    s_waitrequest = '1;
    s_readdata    = '0;
    s_timeout     = '0;
    done          = 1'b0;
    case (state)
      S_IDLE: if (pick_vld) state_nxt = S_BUSY;
      S_BUSY: begin
        if (!avm_waitrequest) begin
          s_waitrequest[grant] = 1'b0;
          s_readdata           = avm_readdata;
          done                 = 1'b1;
          state_nxt            = S_GAP;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          s_waitrequest[grant] = 1'b0;
          s_timeout[grant]     = 1'b1;
          done                 = 1'b1;
          state_nxt            = S_GAP;
        end
`endif
      end
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state         <= S_IDLE;
      grant         <= '0;
      last_grant    <= IW'(NUM_REQ - 1);
      avm_address   <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && pick_vld) begin
        grant         <= pick;
        avm_address   <= s_address[int'(pick)*5 +: 5];
        avm_write     <= s_write[pick];
        // A simultaneous read and write request is served as a write only.
        avm_read      <= s_read[pick] & ~s_write[pick];
        avm_writedata <= s_writedata[int'(pick)*32 +: 32];
      end
      if (done) begin
        avm_read   <= 1'b0;
        avm_write  <= 1'b0;
        last_grant <= grant;
      end
    end
  end

endmodule

// File: tb/tb_uart_avm_arbiter.sv
// tb/tb_uart_avm_arbiter.sv - directed self-checking bench for uart_avm_arbiter
module tb_uart_avm_arbiter;
  import uart_avm_pkg::*;

  logic        avm_clk = 1'b0;
  logic        avm_rst;
  logic [9:0]  s_address;
  logic [1:0]  s_read, s_write;
  logic [63:0] s_writedata;
  logic [31:0] s_readdata;
  logic [1:0]  s_waitrequest, s_timeout;
  logic [4:0]  avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_waitrequest;

  int n_vec = 0;
  int n_err = 0;

  always #5 avm_clk = ~avm_clk;

  uart_avm_arbiter #(.NUM_REQ(2), .TIMEOUT(8)) dut (
    .avm_clk         (avm_clk),
    .avm_rst         (avm_rst),
    .s_address       (s_address),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_writedata     (s_writedata),
    .s_readdata      (s_readdata),
    .s_waitrequest   (s_waitrequest),
    .s_timeout       (s_timeout),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge avm_clk);
    #1;
  endtask

  initial begin
    avm_rst = 1'b1;
    s_address = '0; s_read = '0; s_write = '0; s_writedata = '0;
    avm_readdata = '0; avm_waitrequest = 1'b0;

    #12;
    check("rst_read",   avm_read, 0);
    check("rst_write",  avm_write, 0);
    check("rst_addr",   avm_address, 0);
    check("rst_wdata",  avm_writedata, 0);
    check("rst_swait",  s_waitrequest, 2'b11);
    check("rst_tmo",    s_timeout, 0);
    check("rst_rdata",  s_readdata, 0);

    cyc(); avm_rst = 1'b0; #1;
    check("idle_swait", s_waitrequest, 2'b11);

    // single read by requester 0, three wait cycles
    cyc();
    s_address[4:0] = STATUS_BASE; s_read = 2'b01;
    avm_waitrequest = 1'b1; avm_readdata = 32'h33; #1;
    check("rd_latency", avm_read, 0);
    for (int k = 1; k <= 3; k++) begin
      cyc(); #1;
      check("rd_wait_read",  avm_read, 1);
      check("rd_wait_addr",  avm_address, 8);
      check("rd_wait_swait", s_waitrequest, 2'b11);
      check("rd_wait_rdata", s_readdata, 0);
    end
    cyc(); avm_waitrequest = 1'b0; avm_readdata = 32'h80; #1;
    check("rd_done_read",  avm_read, 1);
    check("rd_done_swait", s_waitrequest, 2'b10);
    check("rd_done_rdata", s_readdata, 32'h80);
    cyc(); s_read = 2'b00; avm_readdata = 32'h55; #1;
    check("rd_gap_read",  avm_read, 0);
    check("rd_gap_swait", s_waitrequest, 2'b11);
    check("rd_gap_rdata", s_readdata, 0);
    cyc(); #1;
    check("rd_idle_read", avm_read, 0);

    // zero-wait write by requester 1
    s_address[9:5] = TX_BASE; s_write = 2'b10; s_writedata[63:32] = 32'h41;
    cyc(); #1;
    check("wr_write", avm_write, 1);
    check("wr_addr",  avm_address, 4);
    check("wr_wdata", avm_writedata, 32'h41);
    check("wr_read",  avm_read, 0);
    check("wr_swait", s_waitrequest, 2'b01);
    cyc(); s_write = 2'b00; #1;
    check("wr_gap_write", avm_write, 0);
    cyc(); #1;

    // read and write together from requester 0
    s_address[4:0] = TX_BASE; s_read = 2'b01; s_write = 2'b01; s_writedata[31:0] = 32'h5A;
    cyc(); #1;
    check("rw_write", avm_write, 1);
    check("rw_read",  avm_read, 0);
    check("rw_wdata", avm_writedata, 32'h5A);
    check("rw_swait", s_waitrequest, 2'b10);
    cyc(); s_read = 2'b00; s_write = 2'b00; #1;
    check("rw_gap_write", avm_write, 0);
    cyc(); #1;

    // reset pulse while requester 1 is stalled
    s_address[9:5] = STATUS_BASE; s_read = 2'b10; avm_waitrequest = 1'b1;
    cyc(); #1;
    check("rm_busy_read", avm_read, 1);
    check("rm_busy_addr", avm_address, 8);
    cyc(); #1;
    avm_rst = 1'b1; #1;
    check("rm_async_read",  avm_read, 0);
    check("rm_async_addr",  avm_address, 0);
    check("rm_async_swait", s_waitrequest, 2'b11);
    cyc(); #1;
    check("rm_hold_swait", s_waitrequest, 2'b11);
    check("rm_hold_read",  avm_read, 0);
    s_address[4:0] = RX_BASE; s_read = 2'b11; avm_waitrequest = 1'b0;
    avm_rst = 1'b0; #1;
    check("rm_release_read", avm_read, 0);

    // contention: requester 0 must win first, then strict alternation
    for (int t = 0; t < 4; t++) begin
      cyc(); #1;
      check("ct_read",  avm_read, 1);
      check("ct_addr",  avm_address, (t % 2) ? 5'd8 : 5'd0);
      check("ct_swait", s_waitrequest, (t % 2) ? 2'b01 : 2'b10);
      cyc(); #1;
      check("ct_gap_read",  avm_read, 0);
      check("ct_gap_swait", s_waitrequest, 2'b11);
      cyc(); #1;
      check("ct_idle_read", avm_read, 0);
    end

    // stalled slave: timeout after 8 wait cycles, or indefinite wait
    s_read = 2'b01; s_address[4:0] = STATUS_BASE;
    avm_waitrequest = 1'b1; avm_readdata = 32'hDEAD;
`ifdef UART_ARB_TIMEOUT_EN
    for (int k = 1; k <= 7; k++) begin
      cyc(); #1;
      check("to_wait_read",  avm_read, 1);
      check("to_wait_tmo",   s_timeout, 0);
      check("to_wait_swait", s_waitrequest, 2'b11);
    end
    cyc(); #1;
    check("to_hit_tmo",   s_timeout, 2'b01);
    check("to_hit_swait", s_waitrequest, 2'b10);
    check("to_hit_rdata", s_readdata, 0);
    cyc(); s_read = 2'b00; #1;
    check("to_drop_read", avm_read, 0);
    check("to_drop_tmo",  s_timeout, 0);
`else
    for (int k = 1; k <= 12; k++) begin
      cyc(); #1;
      check("nto_read",  avm_read, 1);
      check("nto_tmo",   s_timeout, 0);
      check("nto_swait", s_waitrequest, 2'b11);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
